// File: rtl/br_arbitro_pkg.sv
// br_arbitro_pkg: shared FSM encoding, requester ids and default widths
package br_arbitro_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_t;
endpackage

// File: rtl/br_arbitro_if.sv
// br_arbitro_if: requester handshakes plus the register bank port
interface br_arbitro_if import br_arbitro_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              req_a, we_a, gnt_a, rvalid_a;
  logic [ADDR_W-1:0] dir_a;
  logic [DATA_W-1:0] dato_a, rdata_a;
  logic              req_b, we_b, gnt_b, rvalid_b;
  logic [ADDR_W-1:0] dir_b;
  logic [DATA_W-1:0] dato_b, rdata_b;
  logic              bank_en, bank_we, busy;
  logic [ADDR_W-1:0] bank_dir;
  logic [DATA_W-1:0] bank_dato_e, bank_dato_s;
  modport master (
    output req_a, we_a, dir_a, dato_a, req_b, we_b, dir_b, dato_b, bank_dato_s,
    input  gnt_a, rvalid_a, rdata_a, gnt_b, rvalid_b, rdata_b,
    input  bank_en, bank_we, bank_dir, bank_dato_e, busy
  );
  modport slave (
    input  req_a, we_a, dir_a, dato_a, req_b, we_b, dir_b, dato_b, bank_dato_s,
    output gnt_a, rvalid_a, rdata_a, gnt_b, rvalid_b, rdata_b,
    output bank_en, bank_we, bank_dir, bank_dato_e, busy
  );
endinterface

// File: rtl/br_rr2.sv
// br_rr2: two-way round-robin picker favouring the requester not served last
module br_rr2 import br_arbitro_pkg::*; (
  input  logic req_a,
  input  logic req_b,
  input  logic last_srv,
  output logic winner,
  output logic any
);
  assign any = req_a | req_b;
  assign winner = (req_a & req_b) ? ~last_srv : (req_b ? REQ_B : REQ_A);
endmodule

// File: rtl/br_arbitro.sv
// br_arbitro: round-robin sequencer sharing one single-port register bank between two requesters
module br_arbitro import br_arbitro_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic        clk,
  input logic        rst_n,
  br_arbitro_if.slave bus
);
  state_t            state, nxt;
  logic              win, nxt_win, last_srv, nxt_last, winner, any;
  logic              gnt_a, gnt_b, rvalid_a, rvalid_b, bank_en, bank_we, busy;
  logic              nxt_gnt_a, nxt_gnt_b, nxt_rvalid_a, nxt_rvalid_b, nxt_en, nxt_we;
  logic [ADDR_W-1:0] bank_dir, nxt_dir;
  logic [DATA_W-1:0] bank_dato_e, nxt_dato, rdata_a, rdata_b, nxt_rdata_a, nxt_rdata_b;
  br_rr2 u_rr2 (
    .req_a    (bus.req_a),
    .req_b    (bus.req_b),
    .last_srv (last_srv),
    .winner   (winner),
    .any      (any)
  );
  // next state and next registered outputs; bank_dir/bank_dato_e double as the latched operands
  always_comb begin
    nxt          = state;
    nxt_win      = win;
    nxt_last     = last_srv;
    nxt_gnt_a    = 1'b0;
    nxt_gnt_b    = 1'b0;
    nxt_rvalid_a = 1'b0;
    nxt_rvalid_b = 1'b0;
    nxt_en       = 1'b0;
    nxt_we       = 1'b0;
    nxt_dir      = bank_dir;
    nxt_dato     = bank_dato_e;
    nxt_rdata_a  = rdata_a;
    nxt_rdata_b  = rdata_b;
    case (state)
      IDLE: if (any) begin
        nxt       = ACCESS;
        nxt_win   = winner;
        nxt_last  = winner;
        nxt_en    = 1'b1;
        nxt_we    = (winner == REQ_B) ? bus.we_b : bus.we_a;
        nxt_dir   = (winner == REQ_B) ? bus.dir_b : bus.dir_a;
        nxt_dato  = (winner == REQ_B) ? bus.dato_b : bus.dato_a;
        nxt_gnt_a = (winner == REQ_A);
        nxt_gnt_b = (winner == REQ_B);
      end
      ACCESS:  nxt = bank_we ? IDLE : WAIT_RD;
      WAIT_RD: begin
        nxt          = RESP;
        nxt_rvalid_a = (win == REQ_A);
        nxt_rvalid_b = (win == REQ_B);
        nxt_rdata_a  = (win == REQ_A) ? bus.bank_dato_s : rdata_a;
        nxt_rdata_b  = (win == REQ_B) ? bus.bank_dato_s : rdata_b;
      end
      default: nxt = IDLE;
    endcase
  end
  // state and output registers; reset favours A for the first contested grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      win         <= REQ_A;
      last_srv    <= REQ_B;
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      rvalid_a    <= 1'b0;
      rvalid_b    <= 1'b0;
      rdata_a     <= '0;
      rdata_b     <= '0;
      bank_en     <= 1'b0;
      bank_we     <= 1'b0;
      bank_dir    <= '0;
      bank_dato_e <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= nxt;
      win         <= nxt_win;
      last_srv    <= nxt_last;
      gnt_a       <= nxt_gnt_a;
      gnt_b       <= nxt_gnt_b;
      rvalid_a    <= nxt_rvalid_a;
      rvalid_b    <= nxt_rvalid_b;
      rdata_a     <= nxt_rdata_a;
      rdata_b     <= nxt_rdata_b;
      bank_en     <= nxt_en;
      bank_we     <= nxt_we;
      bank_dir    <= nxt_dir;
      bank_dato_e <= nxt_dato;
      busy        <= (nxt != IDLE);
    end
  end
  assign bus.gnt_a       = gnt_a;
  assign bus.gnt_b       = gnt_b;
  assign bus.rvalid_a    = rvalid_a;
  assign bus.rvalid_b    = rvalid_b;
  assign bus.rdata_a     = rdata_a;
  assign bus.rdata_b     = rdata_b;
  assign bus.bank_en     = bank_en;
  assign bus.bank_we     = bank_we;
  assign bus.bank_dir    = bank_dir;
  assign bus.bank_dato_e = bank_dato_e;
  assign bus.busy        = busy;
endmodule

// File: tb/tb_br_arbitro.sv
// tb_br_arbitro: directed checks of br_arbitro against a behavioural 4x8 bank
module tb_br_arbitro;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [7:0] mem [4];
  br_arbitro_if bus ();
  br_arbitro dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // behavioural bank: synchronous write and synchronous read on enabled edges
  always @(posedge clk) begin
    if (bus.bank_en) begin
      if (bus.bank_we) mem[bus.bank_dir] <= bus.bank_dato_e;
      bus.bank_dato_s <= mem[bus.bank_dir];
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_a(input logic w, input logic [1:0] d, input logic [7:0] v);
    bus.req_a = 1'b1; bus.we_a = w; bus.dir_a = d; bus.dato_a = v;
  endtask
  task automatic set_b(input logic w, input logic [1:0] d, input logic [7:0] v);
    bus.req_b = 1'b1; bus.we_b = w; bus.dir_b = d; bus.dato_b = v;
  endtask
  task automatic test_reset();
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.bank_en !== 1'b0 || bus.gnt_a !== 1'b0 || bus.gnt_b !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b en=%b gnt_a=%b gnt_b=%b required all 0", bus.busy, bus.bank_en, bus.gnt_a, bus.gnt_b); end
    checks++; if (bus.rdata_a !== 8'd0 || bus.rdata_b !== 8'd0 || bus.rvalid_a !== 1'b0 || bus.rvalid_b !== 1'b0) begin failures++; $display("FAIL reset_rdata rdata_a=%0d rdata_b=%0d rva=%b rvb=%b required 0", bus.rdata_a, bus.rdata_b, bus.rvalid_a, bus.rvalid_b); end
    rst_n = 1'b1;
    set_a(1'b1, 2'd1, 8'd5);
    tick();
    bus.req_a = 1'b0;
    tick();
    set_a(1'b1, 2'd1, 8'd99);
    tick();
    checks++; if (bus.gnt_a !== 1'b1 || bus.bank_we !== 1'b1) begin failures++; $display("FAIL reset_pre_gnt gnt_a=%b we=%b required 1 1", bus.gnt_a, bus.bank_we); end
    bus.req_a = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({bus.gnt_a, bus.bank_en, bus.bank_we, bus.busy} !== 4'b0000 || bus.bank_dir !== 2'd0 || bus.bank_dato_e !== 8'd0) begin failures++; $display("FAIL reset_async gnt=%b en=%b we=%b busy=%b dir=%0d dato=%0d required 0", bus.gnt_a, bus.bank_en, bus.bank_we, bus.busy, bus.bank_dir, bus.bank_dato_e); end
    tick();
    checks++; if (bus.rvalid_a !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL reset_hold rvalid_a=%b busy=%b required 0 0", bus.rvalid_a, bus.busy); end
    rst_n = 1'b1;
    set_a(1'b0, 2'd1, 8'd0);
    tick();
    bus.req_a = 1'b0;
    tick();
    tick();
    checks++; if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== 8'd5) begin failures++; $display("FAIL reset_no_commit rvalid_a=%b rdata_a=%0d required 1 5", bus.rvalid_a, bus.rdata_a); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.rvalid_a !== 1'b0) begin failures++; $display("FAIL reset_after busy=%b rvalid_a=%b required 0 0", bus.busy, bus.rvalid_a); end
  endtask
  task automatic test_write_read();
    set_a(1'b1, 2'd2, 8'd30);
    tick();
    checks++; if ({bus.gnt_a, bus.gnt_b, bus.bank_en, bus.bank_we, bus.busy} !== 5'b10111 || bus.bank_dir !== 2'd2 || bus.bank_dato_e !== 8'd30) begin failures++; $display("FAIL wr_issue gnt_a=%b gnt_b=%b en=%b we=%b busy=%b dir=%0d dato=%0d required 1 0 1 1 1 2 30", bus.gnt_a, bus.gnt_b, bus.bank_en, bus.bank_we, bus.busy, bus.bank_dir, bus.bank_dato_e); end
    bus.req_a = 1'b0;
    tick();
    checks++; if ({bus.gnt_a, bus.bank_en, bus.busy} !== 3'b000 || mem[2] !== 8'd30) begin failures++; $display("FAIL wr_done gnt_a=%b en=%b busy=%b mem2=%0d required 0 0 0 30", bus.gnt_a, bus.bank_en, bus.busy, mem[2]); end
    set_a(1'b0, 2'd2, 8'd0);
    tick();
    checks++; if (bus.gnt_a !== 1'b1 || bus.bank_we !== 1'b0 || bus.bank_en !== 1'b1) begin failures++; $display("FAIL rd_issue gnt_a=%b we=%b en=%b required 1 0 1", bus.gnt_a, bus.bank_we, bus.bank_en); end
    bus.req_a = 1'b0;
    tick();
    checks++; if (bus.rvalid_a !== 1'b0 || bus.busy !== 1'b1 || bus.bank_en !== 1'b0) begin failures++; $display("FAIL rd_wait rvalid_a=%b busy=%b en=%b required 0 1 0", bus.rvalid_a, bus.busy, bus.bank_en); end
    tick();
    checks++; if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== 8'd30 || bus.rvalid_b !== 1'b0 || bus.rdata_b !== 8'd0) begin failures++; $display("FAIL rd_resp rvalid_a=%b rdata_a=%0d rvalid_b=%b rdata_b=%0d required 1 30 0 0", bus.rvalid_a, bus.rdata_a, bus.rvalid_b, bus.rdata_b); end
    tick();
    checks++; if (bus.rvalid_a !== 1'b0 || bus.busy !== 1'b0 || bus.rdata_a !== 8'd30) begin failures++; $display("FAIL rd_end rvalid_a=%b busy=%b rdata_a=%0d required 0 0 30", bus.rvalid_a, bus.busy, bus.rdata_a); end
  endtask
  task automatic test_simultaneous();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_a(1'b1, 2'd0, 8'd10);
    set_b(1'b1, 2'd1, 8'd20);
    tick();
    checks++; if (bus.gnt_a !== 1'b1 || bus.gnt_b !== 1'b0 || bus.bank_dato_e !== 8'd10) begin failures++; $display("FAIL sim_first gnt_a=%b gnt_b=%b dato=%0d required 1 0 10", bus.gnt_a, bus.gnt_b, bus.bank_dato_e); end
    bus.req_a = 1'b0;
    tick();
    checks++; if (bus.gnt_a !== 1'b0 || bus.gnt_b !== 1'b0) begin failures++; $display("FAIL sim_gap gnt_a=%b gnt_b=%b required 0 0", bus.gnt_a, bus.gnt_b); end
    tick();
    checks++; if (bus.gnt_b !== 1'b1 || bus.gnt_a !== 1'b0 || bus.bank_dir !== 2'd1 || bus.bank_dato_e !== 8'd20) begin failures++; $display("FAIL sim_second gnt_b=%b gnt_a=%b dir=%0d dato=%0d required 1 0 1 20", bus.gnt_b, bus.gnt_a, bus.bank_dir, bus.bank_dato_e); end
    bus.req_b = 1'b0;
    tick();
    set_a(1'b0, 2'd0, 8'd0);
    set_b(1'b0, 2'd1, 8'd0);
    tick();
    checks++; if (bus.gnt_a !== 1'b1 || bus.gnt_b !== 1'b0) begin failures++; $display("FAIL sim_rd_first gnt_a=%b gnt_b=%b required 1 0", bus.gnt_a, bus.gnt_b); end
    bus.req_a = 1'b0;
    tick();
    tick();
    checks++; if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== 8'd10 || bus.rvalid_b !== 1'b0) begin failures++; $display("FAIL sim_rd_a rvalid_a=%b rdata_a=%0d rvalid_b=%b required 1 10 0", bus.rvalid_a, bus.rdata_a, bus.rvalid_b); end
    tick();
    tick();
    checks++; if (bus.gnt_b !== 1'b1) begin failures++; $display("FAIL sim_rd_gnt_b gnt_b=%b required 1", bus.gnt_b); end
    bus.req_b = 1'b0;
    tick();
    tick();
    checks++; if (bus.rvalid_b !== 1'b1 || bus.rdata_b !== 8'd20 || bus.rdata_a !== 8'd10) begin failures++; $display("FAIL sim_rd_b rvalid_b=%b rdata_b=%0d rdata_a=%0d required 1 20 10", bus.rvalid_b, bus.rdata_b, bus.rdata_a); end
    tick();
  endtask
  task automatic test_fairness();
    int idx = 0;
    int both = 0;
    set_a(1'b1, 2'd0, 8'd1);
    set_b(1'b1, 2'd0, 8'd2);
    for (int c = 0; c < 40 && idx < 8; c++) begin
      tick();
      if (bus.gnt_a && bus.gnt_b) both++;
      else if (bus.gnt_a || bus.gnt_b) begin
        checks++; if (bus.gnt_b !== idx[0]) begin failures++; $display("FAIL fair_order grant %0d went to %s required %s", idx, bus.gnt_b ? "B" : "A", idx[0] ? "B" : "A"); end
        idx++;
      end
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    checks++; if (idx != 8) begin failures++; $display("FAIL fair_timeout grants=%0d required 8", idx); end
    checks++; if (both != 0) begin failures++; $display("FAIL fair_overlap cycles_both=%0d required 0", both); end
    tick();
  endtask
  task automatic test_raw();
    set_a(1'b1, 2'd3, 8'd40);
    set_b(1'b0, 2'd3, 8'd0);
    tick();
    checks++; if (bus.gnt_a !== 1'b1 || bus.gnt_b !== 1'b0) begin failures++; $display("FAIL raw_first gnt_a=%b gnt_b=%b required 1 0", bus.gnt_a, bus.gnt_b); end
    bus.req_a = 1'b0;
    tick();
    tick();
    checks++; if (bus.gnt_b !== 1'b1) begin failures++; $display("FAIL raw_gnt_b gnt_b=%b required 1", bus.gnt_b); end
    bus.req_b = 1'b0;
    tick();
    tick();
    checks++; if (bus.rvalid_b !== 1'b1 || bus.rdata_b !== 8'd40 || bus.rvalid_a !== 1'b0 || bus.rdata_a !== 8'd10) begin failures++; $display("FAIL raw_data rvalid_b=%b rdata_b=%0d rvalid_a=%b rdata_a=%0d required 1 40 0 10", bus.rvalid_b, bus.rdata_b, bus.rvalid_a, bus.rdata_a); end
    tick();
  endtask
  task automatic test_operand_change();
    set_a(1'b1, 2'd2, 8'd55);
    tick();
    checks++; if (bus.gnt_a !== 1'b1 || bus.bank_dato_e !== 8'd55) begin failures++; $display("FAIL opc_gnt gnt_a=%b dato=%0d required 1 55", bus.gnt_a, bus.bank_dato_e); end
    bus.req_a = 1'b0;
    bus.dato_a = 8'd77;
    bus.dir_a = 2'd0;
    #2;
    checks++; if (bus.bank_dato_e !== 8'd55 || bus.bank_dir !== 2'd2) begin failures++; $display("FAIL opc_latched dato=%0d dir=%0d required 55 2", bus.bank_dato_e, bus.bank_dir); end
    tick();
    checks++; if (mem[2] !== 8'd55) begin failures++; $display("FAIL opc_stored mem2=%0d required 55", mem[2]); end
    set_a(1'b0, 2'd2, 8'd0);
    tick();
    bus.req_a = 1'b0;
    tick();
    tick();
    checks++; if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== 8'd55) begin failures++; $display("FAIL opc_readback rvalid_a=%b rdata_a=%0d required 1 55", bus.rvalid_a, bus.rdata_a); end
    tick();
  endtask
  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 8'd0;
    bus.bank_dato_s = 8'd0;
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.dir_a = 2'd0; bus.dato_a = 8'd0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.dir_b = 2'd0; bus.dato_b = 8'd0;
    test_reset();
    test_write_read();
    test_simultaneous();
    test_fairness();
    test_raw();
    test_operand_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/br_arbitro.md
Name: br_arbitro

Overview:
- Two-port arbiter/sequencer that shares the single-port 4x8 register bank (BR) between requesters A and B.
- Accepts one operation at a time, using round-robin priority.
- Drives the bank's En/WE/Dir/Dato_e and returns read data to the winning requester with a valid pulse.
- Sits between the datapath clients and the bank instance.

Parameters:
- DATA_W, 8, bank word width
- ADDR_W, 2, bank address width (4 registers)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_a  in  1  requester A operation request; held until gnt_a
- we_a  in  1  A: 1=write, 0=read
- dir_a  in  ADDR_W  A register address
- dato_a  in  DATA_W  A write data
- gnt_a  out  1  one-cycle pulse: A operation accepted and issued to bank
- rvalid_a  out  1  one-cycle pulse: rdata_a holds A read result
- rdata_a  out  DATA_W  last read result for A, held until next A read completes
- req_b, we_b, dir_b, dato_b, gnt_b, rvalid_b, rdata_b: same as A, for requester B
- bank_en  out  1  to BR En
- bank_we  out  1  to BR WE
- bank_dir  out  ADDR_W  to BR Dir
- bank_dato_e  out  DATA_W  to BR Dato_e
- bank_dato_s  in  DATA_W  from BR Dato_s; synchronous read, valid the cycle after a read edge
- busy  out  1  high in every state except IDLE

Behaviour:
- Clocking and reset: all state and outputs are registered on rising clk.
- rst_n=0 clears asynchronously: state=IDLE, gnt_*=0, rvalid_*=0, rdata_*=0, bank_en=0, bank_we=0, bank_dir=0, bank_dato_e=0, busy=0, last_srv=B (so A wins first).
- FSM states: IDLE, ACCESS, WAIT_RD, RESP.
- IDLE:
  - Requests are sampled only in this state.
  - If exactly one req is high, that requester wins.
  - If both are high, the requester other than last_srv wins.
  - At the edge: latch winner id, we, dir, dato; drive bank_en=1, bank_we=we, bank_dir, bank_dato_e; gnt_winner=1; last_srv=winner; go to ACCESS.
  - No req: stay in IDLE, bank_en=0, bank_we=0.
- ACCESS (1 cycle):
  - Bank signals are stable and gnt is high; the bank acts at the closing edge.
  - At the edge: bank_en=0, bank_we=0, gnt=0.
  - Next state is IDLE for a write, WAIT_RD for a read.
- WAIT_RD (1 cycle):
  - bank_dato_s is valid.
  - At the edge: capture it into rdata_winner, set rvalid_winner=1, go to RESP.
- RESP (1 cycle):
  - rvalid_winner=1.
  - At the edge: rvalid cleared, go to IDLE.
- Latency, counted from the IDLE sampling edge:
  - gnt is high in cycle +1.
  - Write is committed at edge +1.
  - rvalid is high in cycle +3.
  - Throughput: write 2 cycles/op, read 4 cycles/op.
- Handshake:
  - A requester holds req and its operands stable until it sees gnt.
  - It deasserts req in the cycle after gnt unless it has a new operation.
  - A req still high at the next IDLE edge counts as a new operation.
- Boundaries:
  - Both req held continuously: grants strictly alternate A,B,A,B.
  - Single requester held continuously: it is served back-to-back with no stall beyond FSM latency.
  - req deasserted before an IDLE edge: no operation, no gnt.
  - Operand changes after gnt: no effect; operands are latched.
  - Read and write to the same dir, A write granted first: B's read returns A's data.
  - rdata of the non-winning requester is never modified.
  - Reset mid-op (any state): outputs clear immediately; a pending write is not committed if reset asserts during ACCESS; no rvalid is produced after reset.
- Width rules: dir/dato pass through unchanged; no arithmetic is performed.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=0, ACCESS=1, WAIT_RD=2, RESP=3)
  - requester id constants (REQ_A=0, REQ_B=1)
  - DATA_W/ADDR_W defaults
- Natural sub-module: br_rr2, a 2-way round-robin picker (inputs req_a, req_b, last_srv; output winner, any).
- The bank BR stays external; the bench instantiates BR plus br_arbitro.

Test Plan:
- Reset: rst_n=0 mid-ACCESS of a write to dir 1 value 8'd99 -> outputs all 0 immediately; after release, a read of dir 1 returns the prior value (not 99); busy=0.
- Single write then read: A writes dir 2 = 8'd30 -> gnt_a in cycle +1, bank_en=1, bank_we=1, bank_dir=2. A then reads dir 2 -> rvalid_a in cycle +3, rdata_a=30, rdata_b unchanged (0).
- Simultaneous requests: A write dir0=8'd10 and B write dir1=8'd20 raised the same cycle after reset -> A granted first, B granted 2 cycles later. Reads return 10 and 20 respectively.
- Fairness: both req held for 8 operations -> gnt sequence A,B,A,B,A,B,A,B; no gnt_a and gnt_b in the same cycle.
- Read-after-write ordering: A writes dir3=8'd40 while B reads dir3 (simultaneous, last_srv=B) -> B receives rdata_b=40 with rvalid_b.
- Operand change after grant: A changes dato_a to 8'd77 in the cycle after gnt_a for a write of 8'd55 -> the bank stores 55.
